// File: rtl/exp_range_reduce.sv
// Range reduction for the CORDIC exp path: |x| = q*ln2 + r, emitted as q and sign-magnitude r,
// with a valid/overflow token delayed to match the exp stage. Define EXP_RR_SAT_EN to saturate out-of-range inputs.
module exp_range_reduce #(
    parameter int EXP_LAT = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] x_in,
    output logic        out_valid,
    output logic [7:0]  q_o,
    output logic [25:0] r_o,
    output logic        ovf_o,
    output logic        res_valid,
    output logic        res_ovf
);
    localparam logic [22:0] LN2     = 23'h58B90C;
    localparam logic [24:0] INV_LN2 = 25'h1715476;
`ifdef EXP_RR_SAT_EN
    localparam logic [30:0] LIM     = 31'h58B90C00;
`endif

    // Stage 1: magnitude, sign and range check
    logic [30:0] w_abs;
    logic        w_sign1;
    logic        w_ovf1;

    assign w_abs   = x_in[31] ? (~x_in[30:0] + 31'd1) : x_in[30:0];
    // A zero magnitude never carries a negative sign
    assign w_sign1 = x_in[31] & (|w_abs);
`ifdef EXP_RR_SAT_EN
    assign w_ovf1  = (x_in == 32'h8000_0000) || (w_abs >= LIM);
`else
    assign w_ovf1  = 1'b0;
`endif

    logic        r_s1_valid, r_s1_sign, r_s1_ovf;
    logic [30:0] r_s1_abs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_abs   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_sign1;
            r_s1_ovf   <= w_ovf1;
            r_s1_abs   <= w_abs;
        end
    end

    // Stage 2: quotient estimate, truncation keeps it at or one below the true quotient
    logic [55:0] w_prod;
    logic [8:0]  w_q_est;

    assign w_prod  = 56'(r_s1_abs) * 56'(INV_LN2);
    assign w_q_est = 9'(w_prod >> 47);

    logic        r_s2_valid, r_s2_sign, r_s2_ovf;
    logic [30:0] r_s2_abs;
    logic [8:0]  r_s2_q_est;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_abs   <= '0;
            r_s2_q_est <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_ovf   <= r_s1_ovf;
            r_s2_abs   <= r_s1_abs;
            r_s2_q_est <= w_q_est;
        end
    end

    // Stage 3: remainder against the estimate
    logic [31:0] w_qln2;
    logic [31:0] w_r3;

    assign w_qln2 = 32'(r_s2_q_est) * 32'(LN2);
    assign w_r3   = 32'(r_s2_abs) - w_qln2;

    logic        r_s3_valid, r_s3_sign, r_s3_ovf;
    logic [8:0]  r_s3_q_est;
    logic [31:0] r_s3_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_s3_ovf   <= 1'b0;
            r_s3_q_est <= '0;
            r_s3_r     <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_sign  <= r_s2_sign;
            r_s3_ovf   <= r_s2_ovf;
            r_s3_q_est <= r_s2_q_est;
            r_s3_r     <= w_r3;
        end
    end

    // Stage 4: single-step correction, output registers hold while no sample arrives
    logic        w_corr;
    logic [8:0]  w_q4;
    logic [31:0] w_r4_full;
    logic [22:0] w_r4;

    assign w_corr    = (r_s3_r >= 32'(LN2));
    assign w_q4      = w_corr ? (r_s3_q_est + 9'd1) : r_s3_q_est;
    assign w_r4_full = w_corr ? (r_s3_r - 32'(LN2)) : r_s3_r;
    assign w_r4      = 23'(w_r4_full);

    logic        r_out_valid;
    logic [7:0]  r_q;
    logic [25:0] r_r;
    logic        r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_ovf <= r_s3_ovf;
`ifdef EXP_RR_SAT_EN
                if (r_s3_ovf) begin
                    r_q <= 8'hFF;
                    r_r <= {r_s3_sign, 2'b00, LN2 - 23'd1};
                end else
`endif
                begin
                    r_q <= 8'(w_q4);
                    r_r <= {r_s3_sign, 2'b00, w_r4};
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign q_o       = r_q;
    assign r_o       = r_r;
    assign ovf_o     = r_ovf;

    // Token delay line matched to the downstream exp latency
    genvar gi;
    generate
        for (gi = 0; gi < EXP_LAT; gi++) begin : g_dly
            logic [1:0] w_tap_in;
            logic [1:0] r_tap;
            if (gi == 0) begin : g_head
                assign w_tap_in = {r_out_valid, r_ovf};
            end else begin : g_body
                assign w_tap_in = g_dly[gi-1].r_tap;
            end
            always_ff @(posedge clk) begin
                if (rst) r_tap <= 2'b00;
                else     r_tap <= w_tap_in;
            end
        end
    endgenerate

    assign res_valid = g_dly[EXP_LAT-1].r_tap[1];
    assign res_ovf   = g_dly[EXP_LAT-1].r_tap[0];
endmodule

// File: tb/tb_exp_range_reduce.sv
// Self-checking bench for exp_range_reduce: vector table, random stream and reset abort,
// all checked through a scoreboard against an integer divide/modulo reference.
module tb_exp_range_reduce;
    localparam int          LAT = 25;
    localparam logic [31:0] LN2 = 32'd5814540;
    localparam logic [25:0] NEG = 26'h2000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] x_in = '0;
    logic        out_valid, ovf_o, res_valid, res_ovf;
    logic [7:0]  q_o;
    logic [25:0] r_o;

    always #5 clk = ~clk;

    exp_range_reduce #(.EXP_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
        .out_valid(out_valid), .q_o(q_o), .r_o(r_o), .ovf_o(ovf_o),
        .res_valid(res_valid), .res_ovf(res_ovf)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [7:0]  q;
        logic [25:0] r;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic        rq[$];
    exp_t        e_mon;
    logic        ovf_mon;
    logic [LAT+3:0] hist = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x);
        exp_t        e;
        logic [31:0] a;
        a     = x[31] ? (~x + 32'd1) : x;
        e.x   = x;
        e.q   = 8'(a / LN2);
        e.r   = {x[31] && (a != 0), 2'b00, 23'(a % LN2)};
`ifdef EXP_RR_SAT_EN
        e.ovf = (a >= 32'h58B90C00);
        if (e.ovf) begin
            e.q = 8'hFF;
            e.r = {x[31], 2'b00, 23'(LN2 - 32'd1)};
        end
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    task automatic push(input exp_t e);
        sb.push_back(e);
        rq.push_back(e.ovf);
    endtask

    task automatic drive(input exp_t e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x_in     = e.x;
        push(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            x_in     = $urandom;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_q_o"},       32'(q_o),       32'd0);
        check({tag, "_r_o"},       32'(r_o),       32'd0);
        check({tag, "_ovf_o"},     32'(ovf_o),     32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_ovf"},   32'(res_ovf),   32'd0);
    endtask

    // Expected valid pattern; reset discards everything in flight
    always @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            sb.delete();
            rq.delete();
        end else begin
            hist <= {hist[LAT+2:0], in_valid};
        end
    end

    always @(negedge clk) begin
        check("out_valid_pattern", 32'(out_valid), 32'(hist[3]));
        check("res_valid_pattern", 32'(res_valid), 32'(hist[LAT+3]));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got q=%0d r=%0h, expected no output", q_o, r_o);
            end else begin
                e_mon = sb.pop_front();
                $display("[TB] out x=%08h q=%0d r=%07h ovf=%0d", e_mon.x, q_o, r_o, ovf_o);
                check("q_o",   32'(q_o),   32'(e_mon.q));
                check("r_o",   32'(r_o),   32'(e_mon.r));
                check("ovf_o", 32'(ovf_o), 32'(e_mon.ovf));
            end
        end
        if (res_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_res: got res_valid=1, expected no result");
            end else begin
                ovf_mon = rq.pop_front();
                check("res_ovf", 32'(res_ovf), 32'(ovf_mon));
            end
        end
    end

    exp_t vecs[11];
    exp_t e;
    logic [31:0] mag;

    initial begin
        vecs[0] = '{32'h00800000, 8'd1,   26'd2574068,        1'b0};
        vecs[1] = '{32'hFE800000, 8'd4,   NEG + 26'd1907664,  1'b0};
        vecs[2] = '{32'h00000000, 8'd0,   26'd0,              1'b0};
        vecs[3] = '{32'h0058B90C, 8'd1,   26'd0,              1'b0};
        vecs[4] = '{32'h0058B90B, 8'd0,   26'd5814539,        1'b0};
        vecs[5] = '{32'h58B90BFF, 8'd255, 26'd5814539,        1'b0};
        vecs[6] = '{32'hA746F401, 8'd255, NEG + 26'd5814539,  1'b0};
        vecs[7] = '{32'hFFA746F4, 8'd1,   NEG,                1'b0};
`ifdef EXP_RR_SAT_EN
        vecs[8]  = '{32'h64000000, 8'd255, 26'd5814539,       1'b1};
        vecs[9]  = '{32'h58B90C00, 8'd255, 26'd5814539,       1'b1};
        vecs[10] = '{32'hA746F400, 8'd255, NEG + 26'd5814539, 1'b1};
`else
        vecs[8]  = '{32'h64000000, 8'd32,  26'd3134080,       1'b0};
        vecs[9]  = '{32'h58B90C00, 8'd0,   26'd0,             1'b0};
        vecs[10] = '{32'hA746F400, 8'd0,   NEG,               1'b0};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // First vector goes in on the very first cycle after reset release
        rst      = 1'b0;
        in_valid = 1'b1;
        x_in     = vecs[0].x;
        push(vecs[0]);
        for (int i = 1; i < 11; i++) drive(vecs[i]);
        idle(8);
        @(negedge clk);
        check("hold_q_o", 32'(q_o), 32'(vecs[10].q));
        check("hold_r_o", 32'(r_o), 32'(vecs[10].r));

        // Random stream: 40 back-to-back, 3-cycle gap, 5 more
        for (int i = 0; i < 45; i++) begin
            if (i == 40) idle(3);
            mag = 32'($urandom_range(0, 32'h58B90BFF));
            e   = model($urandom_range(0, 1) == 1 ? (~mag + 32'd1) : mag);
            drive(e);
        end
        idle(LAT + 10);
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("drain_res", 32'(rq.size()), 32'd0);

        // Reset while 10 samples are in flight; a valid during reset must be ignored
        for (int i = 0; i < 10; i++) drive(model(32'($urandom_range(0, 32'h58B90BFF))));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        x_in     = 32'h00800000;
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_pulse");
        rst      = 1'b0;
        in_valid = 1'b1;
        x_in     = vecs[1].x;
        push(vecs[1]);
        idle(LAT + 10);
        check("post_rst_sb", 32'(sb.size()), 32'd0);
        check("post_rst_res", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
